// File: rtl/branch_resolve_ctrl_if.sv
// Branch resolution bus between the ID-stage decoder (master) and the resolve controller (slave).
// Stats outputs br_count/taken_count exist only when BR_STATS_EN is defined.
interface branch_resolve_ctrl_if;
    // Handshake: br_valid means a decoded branch sits in ID and stays asserted
    // until the controller resolves it (br_done). operand_ready is the "ready"
    // half: while it is low, the controller holds the pipeline with stall_id and
    // waits. Dropping br_valid before resolution withdraws the branch.
    logic        br_valid;
    logic [2:0]  br_type;
    logic        operand_ready;
    logic        EQUAL;
    logic        NotEQUAL;
    logic        IsBiggerThanZero;
    logic        IsLessThanZero;
    logic        IsZero;
    logic [31:0] br_target;

    logic        stall_id;
    logic        flush_if;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        br_done;
    logic        br_taken;
    logic        bad_type;
    logic        wait_timeout;
    logic [1:0]  dbg_state;
`ifdef BR_STATS_EN
    logic [15:0] br_count;
    logic [15:0] taken_count;
`endif

    modport master (
        output br_valid, br_type, operand_ready,
        output EQUAL, NotEQUAL, IsBiggerThanZero, IsLessThanZero, IsZero,
        output br_target,
        input  stall_id, flush_if, pc_src, pc_branch,
        input  br_done, br_taken, bad_type, wait_timeout, dbg_state
`ifdef BR_STATS_EN
        , input br_count, taken_count
`endif
    );

    modport slave (
        input  br_valid, br_type, operand_ready,
        input  EQUAL, NotEQUAL, IsBiggerThanZero, IsLessThanZero, IsZero,
        input  br_target,
        output stall_id, flush_if, pc_src, pc_branch,
        output br_done, br_taken, bad_type, wait_timeout, dbg_state
`ifdef BR_STATS_EN
        , output br_count, taken_count
`endif
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution controller: waits for forwarded operands, resolves in one cycle,
// redirects the PC. Optional branch statistics counters are enabled by defining BR_STATS_EN.
module branch_resolve_ctrl #(
    parameter int unsigned WAIT_MAX = 3
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q;
    logic        timeout_set;
    logic        load_target;
    logic [31:0] pc_branch_q;
    logic        taken;
    logic        illegal;
    logic        in_resolve;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            timeout_q   <= 1'b0;
            pc_branch_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (timeout_set) timeout_q <= 1'b1;
            if (load_target) pc_branch_q <= bus.br_target;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_set = 1'b0;
        load_target = 1'b0;
        case (state_q)
            IDLE: begin
                // Clearing here also covers the clear-on-entry into WAIT.
                wait_cnt_d = 4'd0;
                if (bus.br_valid) begin
                    if (bus.operand_ready) begin
                        state_d     = RESOLVE;
                        load_target = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.br_valid) begin
                    state_d = IDLE;
                end else if (bus.operand_ready) begin
                    state_d     = RESOLVE;
                    load_target = 1'b1;
                end else begin
                    if (wait_cnt_q != 4'hF) wait_cnt_d = wait_cnt_q + 4'd1;
                    if (wait_cnt_d == WAIT_LIM) timeout_set = 1'b1;
                end
            end
            RESOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flags and br_type are sampled live during the RESOLVE cycle.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (bus.br_type)
            3'd0:    taken = bus.EQUAL;
            3'd1:    taken = bus.NotEQUAL;
            3'd2:    taken = bus.IsBiggerThanZero;
            3'd3:    taken = bus.IsLessThanZero;
            3'd4:    taken = bus.IsLessThanZero | bus.IsZero;
            3'd5:    taken = !bus.IsLessThanZero;
            default: illegal = 1'b1;
        endcase
    end

    assign in_resolve       = (state_q == RESOLVE);
    assign bus.stall_id     = ((state_q == IDLE) && bus.br_valid) || (state_q == WAIT);
    assign bus.br_done      = in_resolve;
    assign bus.br_taken     = in_resolve & taken;
    assign bus.pc_src       = in_resolve & taken;
    assign bus.flush_if     = in_resolve & taken;
    assign bus.bad_type     = in_resolve & illegal;
    assign bus.pc_branch    = pc_branch_q;
    assign bus.wait_timeout = timeout_q;
    assign bus.dbg_state    = state_q;

`ifdef BR_STATS_EN
    logic [15:0] br_count_q;
    logic [15:0] taken_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q    <= 16'd0;
            taken_count_q <= 16'd0;
        end else begin
            if (bus.br_done) br_count_q <= br_count_q + 16'd1;
            if (bus.br_done && bus.br_taken) taken_count_q <= taken_count_q + 16'd1;
        end
    end

    assign bus.br_count    = br_count_q;
    assign bus.taken_count = taken_count_q;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed branches push expected resolutions,
// a negedge monitor pops and compares on every br_done.
module tb_branch_resolve_ctrl;
    logic clk;
    logic rst;

    branch_resolve_ctrl_if bus ();

    branch_resolve_ctrl #(.WAIT_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_br   = 0;
    int n_tk   = 0;
    int fto;

    // {bad_type, taken, pc_branch}
    logic [33:0] exp_q[$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.br_valid         = 1'b0;
        bus.br_type          = 3'd0;
        bus.operand_ready    = 1'b0;
        bus.EQUAL            = 1'b0;
        bus.NotEQUAL         = 1'b0;
        bus.IsBiggerThanZero = 1'b0;
        bus.IsLessThanZero   = 1'b0;
        bus.IsZero           = 1'b0;
        bus.br_target        = 32'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // flg = {EQUAL, NotEQUAL, IsBiggerThanZero, IsLessThanZero, IsZero}
    // low = number of cycles operand_ready is held low, counting the first ID cycle.
    task automatic issue(input logic [2:0] t, input logic [31:0] tgt, input logic [4:0] flg,
                         input int low, input logic exp_taken, input logic exp_bad,
                         output int first_to);
        int stalls;
        stalls   = 0;
        first_to = -1;
        exp_q.push_back({exp_bad, exp_taken, tgt});
        n_br++;
        if (exp_taken) n_tk++;
        bus.br_valid      = 1'b1;
        bus.br_type       = t;
        bus.br_target     = tgt;
        {bus.EQUAL, bus.NotEQUAL, bus.IsBiggerThanZero, bus.IsLessThanZero, bus.IsZero} = flg;
        bus.operand_ready = (low == 0);
        for (int i = 0; i <= low; i++) begin
            @(negedge clk);
            if (bus.stall_id) stalls++;
            if (bus.wait_timeout && first_to < 0) first_to = i;
            @(posedge clk);
            #1;
            if (i == low - 1) bus.operand_ready = 1'b1;
        end
        // RESOLVE cycle: target changes to prove pc_branch was registered.
        bus.br_valid  = 1'b0;
        bus.br_target = ~tgt;
        @(negedge clk);
        check("stall_in_resolve", {31'd0, bus.stall_id}, 32'd0);
        @(posedge clk);
        #1;
        clear_inputs();
        check("stall_cycles", stalls, low + 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [33:0] e;
        if (bus.br_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_br_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("br_taken",  {31'd0, bus.br_taken}, {31'd0, e[32]});
                check("pc_src",    {31'd0, bus.pc_src},   {31'd0, e[32]});
                check("flush_if",  {31'd0, bus.flush_if}, {31'd0, e[32]});
                check("bad_type",  {31'd0, bus.bad_type}, {31'd0, e[33]});
                check("pc_branch", bus.pc_branch, e[31:0]);
            end
        end else begin
            check("outs_outside_resolve",
                  {28'd0, bus.br_taken, bus.pc_src, bus.flush_if, bus.bad_type}, 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        clear_inputs();
        idle(2);
        rst = 1'b0;

        // All outputs zero in the cycle after reset
        @(negedge clk);
        check("rst_stall_id",  {31'd0, bus.stall_id},     32'd0);
        check("rst_flush_if",  {31'd0, bus.flush_if},     32'd0);
        check("rst_pc_src",    {31'd0, bus.pc_src},       32'd0);
        check("rst_pc_branch", bus.pc_branch,             32'd0);
        check("rst_br_done",   {31'd0, bus.br_done},      32'd0);
        check("rst_timeout",   {31'd0, bus.wait_timeout}, 32'd0);
        check("rst_state",     {30'd0, bus.dbg_state},    32'd0);
        @(posedge clk);
        #1;

        // BEQ taken, no wait
        issue(3'd0, 32'h0040_0020, 5'b10000, 0, 1'b1, 1'b0, fto);
        // BNE with NotEQUAL=0 -> not taken (back-to-back with previous)
        issue(3'd1, 32'h0040_0040, 5'b10000, 0, 1'b0, 1'b0, fto);
        idle($urandom_range(1, 3));
        // BLEZ, operands late by 2 cycles, IsZero -> taken, no timeout
        issue(3'd4, 32'h0040_0060, 5'b00001, 2, 1'b1, 1'b0, fto);
        check("blez_no_timeout", fto, -1);
        check("blez_timeout_after", {31'd0, bus.wait_timeout}, 32'd0);
        // BGTZ taken / not taken on zero
        issue(3'd2, 32'h0040_0080, 5'b00100, 0, 1'b1, 1'b0, fto);
        issue(3'd2, 32'h0040_00A0, 5'b00001, 1, 1'b0, 1'b0, fto);
        // BLTZ taken
        issue(3'd3, 32'h0040_00C0, 5'b00010, 0, 1'b1, 1'b0, fto);
        // BGEZ not taken when negative, taken on zero
        issue(3'd5, 32'h0040_00E0, 5'b00010, 0, 1'b0, 1'b0, fto);
        issue(3'd5, 32'h0040_0100, 5'b00001, 0, 1'b1, 1'b0, fto);
        idle($urandom_range(1, 3));
        // Illegal types: bad_type pulse, never taken even with all flags set
        issue(3'd7, 32'h0040_0120, 5'b11111, 0, 1'b0, 1'b1, fto);
        issue(3'd6, 32'h0040_0140, 5'b11111, 1, 1'b0, 1'b1, fto);

        // br_valid withdrawn in WAIT -> IDLE, no resolution
        bus.br_valid      = 1'b1;
        bus.br_type       = 3'd0;
        bus.EQUAL         = 1'b1;
        bus.operand_ready = 1'b0;
        idle(1);
        bus.br_valid = 1'b0;
        @(negedge clk);
        check("abort_wait_state", {30'd0, bus.dbg_state}, 32'd1);
        check("abort_wait_stall", {31'd0, bus.stall_id},  32'd1);
        @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        check("abort_idle_state", {30'd0, bus.dbg_state}, 32'd0);
        check("abort_idle_stall", {31'd0, bus.stall_id},  32'd0);
        @(posedge clk);
        #1;

        // Timeout: operands late 5 cycles, flag visible after third WAIT cycle
        issue(3'd0, 32'h0040_0200, 5'b10000, 5, 1'b1, 1'b0, fto);
        check("timeout_rise_cycle", fto, 4);
        issue(3'd1, 32'h0040_0220, 5'b01000, 0, 1'b1, 1'b0, fto);
        idle(2);
        @(negedge clk);
        check("timeout_sticky", {31'd0, bus.wait_timeout}, 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-WAIT with br_valid still high at the reset edge
        bus.br_valid      = 1'b1;
        bus.br_type       = 3'd0;
        bus.br_target     = 32'hDEAD_BEEF;
        bus.operand_ready = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        clear_inputs();
        n_br = 0;
        n_tk = 0;
        @(negedge clk);
        check("rstw_state",     {30'd0, bus.dbg_state},    32'd0);
        check("rstw_stall",     {31'd0, bus.stall_id},     32'd0);
        check("rstw_timeout",   {31'd0, bus.wait_timeout}, 32'd0);
        check("rstw_pc_branch", bus.pc_branch,             32'd0);
        @(posedge clk);
        #1;

        // Three back-to-back branches, two taken
        issue(3'd0, 32'h0040_0300, 5'b10000, 0, 1'b1, 1'b0, fto);
        issue(3'd1, 32'h0040_0320, 5'b10000, 1, 1'b0, 1'b0, fto);
        issue(3'd3, 32'h0040_0340, 5'b00010, 0, 1'b1, 1'b0, fto);
        check("post_rst_no_timeout", fto, -1);
`ifdef BR_STATS_EN
        @(negedge clk);
        check("br_count",    {16'd0, bus.br_count},    n_br);
        check("taken_count", {16'd0, bus.taken_count}, n_tk);
`endif
        idle(2);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Branches since last reset: %0d issued, %0d taken", n_br, n_tk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
